// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch for the miriscv core.
// A Moore FSM fetches one instruction, holds it for the decoder and then picks the next PC on retire.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        retire_i,
  input  logic        branch_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        alu_flag_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] pc_o,
  output logic [31:0] link_o,
  output logic        misalign_o,
  output logic [31:0] bad_addr_o,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req_o is held with a stable address until imem_gnt_i is seen
  // in the same cycle; exactly one imem_rvalid_i answers each grant, no earlier
  // than the cycle after it. retire_i only counts while instr_valid_o is high.

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] bad_addr;
  logic        discard;
  logic [31:0] target;
  logic        misaligned;
  logic        take_rdata;
  logic        do_retire;

  always_comb begin
    if (jalr_i) begin
      target = (rs1_i + imm_i) & ~32'h1;
    end else if (jal_i || (branch_i && alu_flag_i)) begin
      target = pc + imm_i;
    end else begin
      target = pc + 32'd4;
    end
  end

  assign misaligned = |target[1:0];
  // A response that belongs to a fetch cancelled by reset never reaches instr.
  assign take_rdata = (state == WAIT) && imem_rvalid_i && !discard;
  assign do_retire  = (state == ISSUE) && retire_i;

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (imem_gnt_i) state_next = WAIT;
      WAIT:    if (take_rdata) state_next = ISSUE;
      ISSUE:   if (retire_i) state_next = misaligned ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_ADDR;
      instr    <= '0;
      bad_addr <= '0;
      discard  <= (state == WAIT);
    end else begin
      state <= state_next;
      if (discard && imem_rvalid_i) begin
        discard <= 1'b0;
      end
      if (take_rdata) begin
        instr <= imem_rdata_i;
      end
      if (do_retire) begin
        if (misaligned) begin
          bad_addr <= target;
        end else begin
          pc <= target;
        end
      end
    end
  end

  assign imem_req_o    = (state == FETCH);
  assign imem_addr_o   = pc;
  assign instr_valid_o = (state == ISSUE);
  assign misalign_o    = (state == HALT);
  assign instr_o       = instr;
  assign pc_o          = pc;
  assign link_o        = pc + 32'd4;
  assign bad_addr_o    = bad_addr;
  assign dbg_state     = state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: next-PC vector table, a fetched-instruction
// scoreboard, and hand-written stall / reset-discard sequences.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        retire_i;
  logic        branch_i;
  logic        jal_i;
  logic        jalr_i;
  logic        alu_flag_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic [31:0] pc_o;
  logic [31:0] link_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;
  logic [1:0]  dbg_state;

  fetch_pc_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .retire_i(retire_i),
    .branch_i(branch_i), .jal_i(jal_i), .jalr_i(jalr_i), .alu_flag_i(alu_flag_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .pc_o(pc_o), .link_o(link_o),
    .misalign_o(misalign_o), .bad_addr_o(bad_addr_o), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks; inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    retire_i = 0; branch_i = 0; jal_i = 0; jalr_i = 0; alu_flag_i = 0;
    imm_i = '0; rs1_i = '0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic wait_issue(input string name);
    int n = 0;
    while (!instr_valid_o && n < 20) begin
      tick(); n++;
    end
    check({name, "_valid"}, instr_valid_o, 1);
    if (exp_q.size() > 0) begin
      last_instr = exp_q.pop_front();
      check({name, "_instr"}, instr_o, last_instr);
    end
  endtask

  task automatic do_fetch(input string name, input logic [31:0] data, input int gd,
                          input int rd, input logic [31:0] exp_addr);
    check({name, "_req"}, imem_req_o, 1);
    check({name, "_addr"}, imem_addr_o, exp_addr);
    for (int i = 0; i < gd; i++) begin
      tick();
      check({name, "_stall_addr"}, {imem_req_o, imem_addr_o[30:0]}, {1'b1, exp_addr[30:0]});
      check({name, "_stall_valid"}, instr_valid_o, 0);
    end
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    check({name, "_wait_req"}, imem_req_o, 0);
    for (int i = 0; i < rd; i++) begin
      tick();
      check({name, "_wait_valid"}, instr_valid_o, 0);
    end
    imem_rvalid_i = 1; imem_rdata_i = data; exp_q.push_back(data);
    tick();
    imem_rvalid_i = 0; imem_rdata_i = $urandom;
    wait_issue(name);
  endtask

  task automatic do_retire(input logic br, input logic jl, input logic jr, input logic fl,
                           input logic [31:0] imm, input logic [31:0] rs1);
    retire_i = 1; branch_i = br; jal_i = jl; jalr_i = jr; alu_flag_i = fl;
    imm_i = imm; rs1_i = rs1;
    tick();
    clear_ctrl();
  endtask

  // next-PC vectors; expected values worked out by hand
  typedef struct {
    logic        br, jl, jr, fl;
    logic [31:0] imm, rs1, start, exp_pc, exp_bad;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 32'h0,        32'h0,    32'h10,       32'h14,       32'h0,        0};
    vecs[1]  = '{1, 0, 0, 1, 32'hFFFFFFF8, 32'h0,    32'h20,       32'h18,       32'h0,        0};
    vecs[2]  = '{1, 0, 0, 0, 32'hFFFFFFF8, 32'h0,    32'h20,       32'h24,       32'h0,        0};
    vecs[3]  = '{0, 1, 1, 0, 32'h4,        32'h1003, 32'h40,       32'h40,       32'h1006,     1};
    vecs[4]  = '{0, 1, 0, 0, 32'h100,      32'h0,    32'h8,        32'h108,      32'h0,        0};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,        32'h0,    32'hFFFFFFFC, 32'h0,        32'h0,        0};
    vecs[6]  = '{1, 0, 1, 1, 32'hFFFFFFFC, 32'h2000, 32'h10,       32'h1FFC,     32'h0,        0};
    vecs[7]  = '{1, 0, 0, 1, 32'h2,        32'h0,    32'h30,       32'h30,       32'h32,       1};
    vecs[8]  = '{0, 0, 1, 0, 32'h0,        32'h101,  32'h0,        32'h100,      32'h0,        0};
    vecs[9]  = '{1, 1, 0, 0, 32'hFFFFFFF0, 32'h0,    32'h50,       32'h40,       32'h0,        0};
    vecs[10] = '{0, 0, 0, 1, 32'h80,       32'h0,    32'h60,       32'h64,       32'h0,        0};
    vecs[11] = '{0, 1, 0, 0, 32'h7FFFFFFE, 32'h0,    32'h0,        32'h0,        32'h7FFFFFFE, 1};
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] exp_link;
    rst = 1; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    clear_ctrl();
    tick();
    rst = 0;

    // reset state
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", imem_req_o, 1);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_bad", bad_addr_o, 32'h0);
    check("rst_link", link_o, 32'h4);
    check("rst_state", dbg_state, 2'd0);

    // first fetch: grant one cycle after the request appears
    do_fetch("first", 32'h00500093, 1, 0, 32'h0);

    // reset wins over a simultaneous retire/jump
    rst = 1; retire_i = 1; jal_i = 1; imm_i = 32'h40;
    tick();
    rst = 0; clear_ctrl();
    check("rstwin_pc", pc_o, 32'h0);
    check("rstwin_req", imem_req_o, 1);
    check("rstwin_valid", instr_valid_o, 0);

    // table-driven next-PC vectors
    for (int i = 0; i < 12; i++) begin
      do_reset();
      do_fetch($sformatf("v%0d_f0", i), 32'h0000006F, $urandom_range(0, 2), $urandom_range(0, 2), 32'h0);
      if (vecs[i].start != 32'h0) begin
        do_retire(0, 1, 0, 0, vecs[i].start, 32'h0);
        do_fetch($sformatf("v%0d_f1", i), $urandom, $urandom_range(0, 2), $urandom_range(0, 2), vecs[i].start);
      end
      do_retire(vecs[i].br, vecs[i].jl, vecs[i].jr, vecs[i].fl, vecs[i].imm, vecs[i].rs1);
      exp_link = vecs[i].exp_pc + 32'd4;
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      check($sformatf("v%0d_link", i), link_o, exp_link);
      check($sformatf("v%0d_misalign", i), misalign_o, vecs[i].exp_halt);
      check($sformatf("v%0d_bad", i), bad_addr_o, vecs[i].exp_bad);
      check($sformatf("v%0d_req", i), imem_req_o, !vecs[i].exp_halt);
      if (!vecs[i].exp_halt) check($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].exp_pc);
      else begin
        for (int k = 0; k < 4; k++) begin
          imem_gnt_i = 1'($urandom_range(0, 1));
          imem_rvalid_i = 1'($urandom_range(0, 1));
          tick();
          check($sformatf("v%0d_halt_req", i), {imem_req_o, misalign_o, instr_valid_o}, 3'b010);
        end
        imem_gnt_i = 0; imem_rvalid_i = 0;
      end
    end

    // memory stall, then a spurious rvalid while the instruction is held
    do_reset();
    do_fetch("stall", 32'h00A00113, 5, 3, 32'h0);
    imem_rvalid_i = 1; imem_rdata_i = 32'hCAFEF00D;
    tick();
    imem_rvalid_i = 0;
    check("spur_instr", instr_o, last_instr);
    check("spur_valid", instr_valid_o, 1);
    check("spur_pc", pc_o, 32'h0);

    // random sequential stream
    exp_pc = 32'h0;
    do_retire(0, 0, 0, 0, 32'h0, 32'h0);
    exp_pc = exp_pc + 4;
    for (int i = 0; i < 6; i++) begin
      do_fetch($sformatf("seq%0d", i), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), exp_pc);
      do_retire(0, 0, 0, 0, $urandom, $urandom);
      exp_pc = exp_pc + 4;
      check($sformatf("seq%0d_pc", i), pc_o, exp_pc);
    end

    // reset in WAIT; stale response arrives in FETCH
    do_reset();
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    rst = 1; tick(); rst = 0;
    imem_rvalid_i = 1; imem_rdata_i = 32'hDEADBEEF; tick(); imem_rvalid_i = 0;
    check("staleF_req", imem_req_o, 1);
    do_fetch("staleF", 32'h00000013, 0, 1, 32'h0);

    // reset in WAIT; stale response arrives in the new fetch's WAIT
    do_reset();
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    rst = 1; tick(); rst = 0;
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    imem_rvalid_i = 1; imem_rdata_i = 32'hDEADBEEF; tick();
    check("staleW_valid", instr_valid_o, 0);
    imem_rdata_i = 32'h00000013; exp_q.push_back(32'h00000013); tick(); imem_rvalid_i = 0;
    wait_issue("staleW");

    // reset in WAIT; stale response coincides with the next grant
    do_reset();
    imem_gnt_i = 1; tick(); imem_gnt_i = 0;
    rst = 1; tick(); rst = 0;
    imem_gnt_i = 1; imem_rvalid_i = 1; imem_rdata_i = 32'hDEADBEEF; tick();
    imem_gnt_i = 0; imem_rvalid_i = 0;
    check("staleG_valid", instr_valid_o, 0);
    check("staleG_req", imem_req_o, 0);
    imem_rvalid_i = 1; imem_rdata_i = 32'h00100093; exp_q.push_back(32'h00100093); tick();
    imem_rvalid_i = 0;
    wait_issue("staleG");

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
